// File: rtl/mem_ctrl.sv
// Byte-wide RAM port controller: serialises LSB loads/stores and instruction fetches into
// single-byte RAM accesses and returns one-cycle done pulses with assembled, extended data.
module mem_ctrl #(
  parameter logic [1:0] IO_HI = 2'b11
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic        io_buffer_full,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        if_en,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_enable,
  input  logic [31:0] addr,
  input  logic [31:0] store_val,
  input  logic [3:0]  lsb_type,
  output logic        ls_finished,
  output logic [31:0] load_val
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

  state_e      state_q, state_d;
  logic        owner_ls_q, owner_ls_d;
  logic [2:0]  size_q, size_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  ext_q, ext_d;
  logic [31:0] a_q, a_d;
  logic [31:0] prev_q;
  logic [31:0] buf_q, buf_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  dout_q, dout_d;
  logic        kill_q, kill_d;
  logic        ls_fin_q, ls_fin_d;
  logic        if_done_q, if_done_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] load_val_q, load_val_d;

  logic        io_block;
  logic        no_done;
  logic [2:0]  req_size;

  assign io_block = lsb_type[3] && (addr[17:16] == IO_HI) && io_buffer_full;
  assign no_done  = !ls_fin_q && !if_done_q;
  assign req_size = lsb_type[1] ? 3'd4 : (lsb_type[0] ? 3'd2 : 3'd1);

  always_comb begin
    state_d    = state_q;
    owner_ls_d = owner_ls_q;
    size_d     = size_q;
    cnt_d      = cnt_q;
    ext_d      = ext_q;
    a_d        = a_q;
    buf_d      = buf_q;
    wdata_d    = wdata_q;
    dout_d     = dout_q;
    kill_d     = kill_q;
    ls_fin_d   = 1'b0;
    if_done_d  = 1'b0;
    if_data_d  = if_data_q;
    load_val_d = load_val_q;

    unique case (state_q)
      StIdle: begin
        if (no_done && ls_enable && !clear && !io_block) begin
          owner_ls_d = 1'b1;
          size_d     = req_size;
          ext_d      = lsb_type[2:0];
          a_d        = addr;
          cnt_d      = 3'd0;
          buf_d      = 32'd0;
          kill_d     = 1'b0;
          if (lsb_type[3]) begin
            state_d = StWrite;
            dout_d  = store_val[7:0];
            wdata_d = store_val >> 8;
          end else begin
            state_d = StRead;
          end
        end else if (no_done && if_en && !clear) begin
          owner_ls_d = 1'b0;
          size_d     = 3'd4;
          a_d        = if_addr;
          cnt_d      = 3'd0;
          buf_d      = 32'd0;
          state_d    = StRead;
        end
      end

      StRead: begin
        if (clear) begin
          state_d = StIdle;
          a_d     = 32'd0;
        end else begin
          // Byte cnt-1 is on mem_din now: it was addressed in the previous cycle.
          if (cnt_q != 3'd0) begin
            buf_d = buf_q | ({24'd0, mem_din} << {cnt_q - 3'd1, 3'b000});
          end
          if (cnt_q == size_q) begin
            state_d = StIdle;
            if (owner_ls_q) begin
              ls_fin_d = 1'b1;
              unique case (ext_q)
                3'b000:  load_val_d = {{24{buf_d[7]}}, buf_d[7:0]};
                3'b100:  load_val_d = {24'd0, buf_d[7:0]};
                3'b001:  load_val_d = {{16{buf_d[15]}}, buf_d[15:0]};
                3'b101:  load_val_d = {16'd0, buf_d[15:0]};
                default: load_val_d = buf_d;
              endcase
            end else begin
              if_done_d = 1'b1;
              if_data_d = buf_d;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q + 3'd1 < size_q) a_d = a_q + 32'd1;
          end
        end
      end

      StWrite: begin
        // A committed store always completes; clear only silences its done pulse.
        if (clear) kill_d = 1'b1;
        if (cnt_q == size_q - 3'd1) begin
          state_d    = StIdle;
          ls_fin_d   = !(kill_q || clear);
          load_val_d = 32'd0;
        end else begin
          cnt_d   = cnt_q + 3'd1;
          a_d     = a_q + 32'd1;
          dout_d  = wdata_q[7:0];
          wdata_d = wdata_q >> 8;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= StIdle;
      owner_ls_q <= 1'b0;
      size_q     <= 3'd0;
      cnt_q      <= 3'd0;
      ext_q      <= 3'd0;
      a_q        <= 32'd0;
      prev_q     <= 32'd0;
      buf_q      <= 32'd0;
      wdata_q    <= 32'd0;
      dout_q     <= 8'd0;
      kill_q     <= 1'b0;
      ls_fin_q   <= 1'b0;
      if_done_q  <= 1'b0;
      if_data_q  <= 32'd0;
      load_val_q <= 32'd0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      owner_ls_q <= owner_ls_d;
      size_q     <= size_d;
      cnt_q      <= cnt_d;
      ext_q      <= ext_d;
      a_q        <= a_d;
      prev_q     <= a_q;
      buf_q      <= buf_d;
      wdata_q    <= wdata_d;
      dout_q     <= dout_d;
      kill_q     <= kill_d;
      ls_fin_q   <= ls_fin_d;
      if_done_q  <= if_done_d;
      if_data_q  <= if_data_d;
      load_val_q <= load_val_d;
    end
  end

  // While paused mid-read, keep re-presenting the previous address so the byte expected on
  // mem_din after the pause is still the one the read sequence is waiting for.
  assign mem_a       = (state_q == StRead && !rdy_in) ? prev_q : a_q;
  assign mem_wr      = rdy_in && (state_q == StWrite);
  assign mem_dout    = dout_q;
  assign if_done     = if_done_q;
  assign if_data     = if_data_q;
  assign ls_finished = ls_fin_q;
  assign load_val    = load_val_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: directed timing cases plus randomized LSB/IF traffic checked
// against a byte-array memory model.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear;
  logic        io_buffer_full;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        if_en;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_enable;
  logic [31:0] addr;
  logic [31:0] store_val;
  logic [3:0]  lsb_type;
  logic        ls_finished;
  logic [31:0] load_val;

  mem_ctrl #(.IO_HI(2'b11)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
    .mem_wr(mem_wr), .if_en(if_en), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_enable(ls_enable), .addr(addr), .store_val(store_val), .lsb_type(lsb_type),
    .ls_finished(ls_finished), .load_val(load_val)
  );

  always #5 clk_in = ~clk_in;

  logic [7:0] ram    [0:262143];
  logic [7:0] shadow [0:262143];

  always @(posedge clk_in) begin
    if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
    mem_din <= ram[mem_a[17:0]];
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          at;
  } exp_t;
  exp_t ls_q[$];
  exp_t if_q[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int op_size(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a, input int n);
    logic [31:0] raw, ai;
    raw = 32'd0;
    for (int i = 0; i < n; i++) begin
      ai  = a + 32'(i);
      raw = raw | (32'(shadow[ai[17:0]]) << (8 * i));
    end
    return raw;
  endfunction

  function automatic logic [31:0] model_load(input logic [3:0] t, input logic [31:0] a);
    int n;
    logic [31:0] raw;
    if (t[3]) return 32'd0;
    n   = op_size(t[1:0]);
    raw = model_word(a, n);
    if (!t[2] && n == 1 && raw >= 32'd128)   raw = raw - 32'd256;
    if (!t[2] && n == 2 && raw >= 32'd32768) raw = raw - 32'd65536;
    return raw;
  endfunction

  function automatic void model_store(input logic [3:0] t, input logic [31:0] a,
                                      input logic [31:0] v);
    logic [31:0] ai;
    for (int i = 0; i < op_size(t[1:0]); i++) begin
      ai = a + 32'(i);
      shadow[ai[17:0]] = 8'(v >> (8 * i));
    end
  endfunction

  // Monitor: every done pulse pops the oldest expectation of its requester.
  always @(negedge clk_in) begin
    if (rst_in) begin
      if (ls_finished) begin
        if (ls_q.size() == 0) check("ls_spurious_done", {31'd0, ls_finished}, 32'd0);
        else begin
          mon_e = ls_q.pop_front();
          check("load_val", load_val, mon_e.data);
          if (mon_e.at >= 0) check("ls_done_cycle", 32'(cyc), 32'(mon_e.at));
        end
      end
      if (if_done) begin
        if (if_q.size() == 0) check("if_spurious_done", {31'd0, if_done}, 32'd0);
        else begin
          mon_e = if_q.pop_front();
          check("if_data", if_data, mon_e.data);
          if (mon_e.at >= 0) check("if_done_cycle", 32'(cyc), 32'(mon_e.at));
        end
      end
    end
  end

  // Called at a negedge (cycle 0); returns at the negedge of the done cycle.
  task automatic lsb_op(input logic [3:0] t, input logic [31:0] a, input logic [31:0] v,
                        input int lat);
    logic got;
    ls_q.push_back('{data: model_load(t, a), at: (lat < 0) ? -1 : cyc + lat});
    if (t[3]) model_store(t, a, v);
    lsb_type  = t;
    addr      = a;
    store_val = v;
    ls_enable = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk_in);
      if (ls_finished) got = 1'b1;
    end
    ls_enable = 1'b0;
    check("ls_handshake", {31'd0, got}, 32'd1);
  endtask

  task automatic if_op(input logic [31:0] a, input int lat);
    logic got;
    if_q.push_back('{data: model_word(a, 4), at: (lat < 0) ? -1 : cyc + lat});
    if_addr = a;
    if_en   = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk_in);
      if (if_done) got = 1'b1;
    end
    if_en = 1'b0;
    check("if_handshake", {31'd0, got}, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  logic [3:0] ops [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b1000, 4'b1001,
                          4'b1010};

  initial begin
    int bad;
    rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
    if_en = 1'b0; if_addr = 32'd0; ls_enable = 1'b0; addr = 32'd0;
    store_val = 32'd0; lsb_type = 4'd0;
    for (int i = 0; i < 262144; i++) begin
      ram[i]    = 8'($urandom);
      shadow[i] = ram[i];
    end
    ram[32'h100] = 8'h78; ram[32'h101] = 8'h56; ram[32'h102] = 8'h34; ram[32'h103] = 8'h12;
    ram[32'h80]  = 8'h80; ram[32'h300] = 8'h01; ram[32'h301] = 8'h80;
    foreach (shadow[i]) shadow[i] = ram[i];

    idle(2);
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("rst_if_done", {31'd0, if_done}, 32'd0);
    check("rst_if_data", if_data, 32'd0);
    check("rst_ls_finished", {31'd0, ls_finished}, 32'd0);
    check("rst_load_val", load_val, 32'd0);
    rst_in = 1'b1;
    idle(2);

    // LW with per-cycle address trace.
    fork
      lsb_op(4'b0010, 32'h100, 32'd0, 6);
      begin
        for (int k = 1; k <= 4; k++) begin
          @(negedge clk_in);
          check("lw_mem_a", mem_a, 32'h100 + 32'(k - 1));
          check("lw_mem_wr", {31'd0, mem_wr}, 32'd0);
        end
      end
    join
    check("lw_value", load_val, 32'h1234_5678);
    idle(1);

    lsb_op(4'b0000, 32'h80, 32'd0, 3);  idle(1);
    check("lb_value", load_val, 32'hFFFF_FF80);
    lsb_op(4'b0100, 32'h80, 32'd0, 3);  idle(1);
    check("lbu_value", load_val, 32'h0000_0080);
    lsb_op(4'b0001, 32'h300, 32'd0, 4); idle(1);
    check("lh_value", load_val, 32'hFFFF_8001);
    lsb_op(4'b0101, 32'h300, 32'd0, 4); idle(1);

    // SH write trace.
    fork
      lsb_op(4'b1001, 32'h200, 32'hAABB_CCDD, 3);
      begin
        for (int k = 1; k <= 2; k++) begin
          @(negedge clk_in);
          check("sh_mem_wr", {31'd0, mem_wr}, 32'd1);
          check("sh_mem_a", mem_a, 32'h200 + 32'(k - 1));
          check("sh_mem_dout", {24'd0, mem_dout}, (k == 1) ? 32'hDD : 32'hCC);
        end
      end
    join
    check("sh_ram", {16'd0, ram[32'h201], ram[32'h200]}, 32'h0000_CCDD);
    idle(1);

    // Simultaneous requests: LSB first, fetch after the gap.
    fork
      lsb_op(4'b0010, 32'h104, 32'd0, 6);
      if_op(32'h40, 13);
    join
    idle(1);

    // Fetch aborted by clear in cycle 3; controller idle in cycle 4.
    if_addr = 32'h44;
    if_en   = 1'b1;
    idle(3);
    clear = 1'b1;
    if_en = 1'b0;
    idle(1);
    clear = 1'b0;
    check("abort_mem_a", mem_a, 32'd0);
    fork
      lsb_op(4'b0000, 32'h80, 32'd0, 3);
      begin
        idle(2);
        check("abort_no_if_done", {31'd0, if_done}, 32'd0);
      end
    join
    idle(4);

    // SW with clear in cycle 2: all bytes land, no done pulse.
    model_store(4'b1010, 32'h210, 32'h1122_3344);
    lsb_type = 4'b1010; addr = 32'h210; store_val = 32'h1122_3344; ls_enable = 1'b1;
    idle(2);
    clear = 1'b1;
    ls_enable = 1'b0;
    check("swclr_wr_c2", {31'd0, mem_wr}, 32'd1);
    idle(1);
    clear = 1'b0;
    check("swclr_wr_c3", {31'd0, mem_wr}, 32'd1);
    idle(1);
    check("swclr_wr_c4", {31'd0, mem_wr}, 32'd1);
    idle(1);
    check("swclr_no_done", {31'd0, ls_finished}, 32'd0);
    check("swclr_ram", {ram[32'h213], ram[32'h212], ram[32'h211], ram[32'h210]}, 32'h1122_3344);
    idle(2);

    // IO store held off by a full UART buffer.
    shadow[18'h30000] = 8'h5A;
    io_buffer_full = 1'b1;
    lsb_type = 4'b1000; addr = 32'h0003_0000; store_val = 32'h1234_565A; ls_enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      idle(1);
      check("io_hold_wr", {31'd0, mem_wr}, 32'd0);
    end
    io_buffer_full = 1'b0;
    ls_q.push_back('{data: 32'd0, at: cyc + 2});
    idle(1);
    check("io_wr", {31'd0, mem_wr}, 32'd1);
    check("io_mem_a", mem_a, 32'h0003_0000);
    check("io_dout", {24'd0, mem_dout}, 32'h5A);
    idle(1);
    check("io_done", {31'd0, ls_finished}, 32'd1);
    ls_enable = 1'b0;
    idle(2);

    // rdy_in low for three edges stretches LW latency by three.
    fork
      lsb_op(4'b0010, 32'h100, 32'd0, 9);
      begin
        idle(2);
        rdy_in = 1'b0;
        idle(3);
        rdy_in = 1'b1;
      end
    join
    idle(1);

    // Reset in the middle of a SW: only the first byte was written.
    shadow[18'h220] = 8'h0D;
    lsb_type = 4'b1010; addr = 32'h220; store_val = 32'hCAFE_F00D; ls_enable = 1'b1;
    idle(2);
    rst_in = 1'b0;
    ls_enable = 1'b0;
    #1;
    check("midrst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("midrst_mem_a", mem_a, 32'd0);
    check("midrst_load_val", load_val, 32'd0);
    idle(1);
    rst_in = 1'b1;
    idle(2);
    check("midrst_ram", {ram[32'h223], ram[32'h222], ram[32'h221], ram[32'h220]},
          {shadow[18'h223], shadow[18'h222], shadow[18'h221], shadow[18'h220]});

    // Randomized concurrent traffic from both requesters.
    fork
      begin
        repeat (60) begin
          idle($urandom_range(0, 3));
          lsb_op(ops[$urandom_range(0, 7)], 32'h1000 + 32'($urandom_range(0, 255)),
                 $urandom, -1);
        end
      end
      begin
        repeat (40) begin
          idle($urandom_range(0, 4));
          if_op(32'($urandom_range(0, 63)) << 2, -1);
        end
      end
    join
    idle(4);

    check("ls_queue_drained", 32'(ls_q.size()), 32'd0);
    check("if_queue_drained", 32'(if_q.size()), 32'd0);
    bad = 0;
    for (int i = 0; i < 262144; i++) if (ram[i] !== shadow[i]) bad++;
    check("ram_image", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
